// File: rtl/alu_mdu.sv
// Execute-stage integer ALU with iterative RV32M multiply/divide.
// Base ops finish in one cycle; MUL*/DIV* take XLEN shift-add / restoring-divide steps.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            res_last_bit,
  output logic [1:0]      dbg_state
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4,  OP_SLT = 5'd5,  OP_SLTU = 5'd6, OP_SLL = 5'd7;
  localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA = 5'd9;
  localparam logic [4:0] OP_MULH = 5'd17, OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              r_state;
  logic [1:0]          r_sel;
  logic [SHW-1:0]      r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_mcand;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_div;
  logic                r_neg;
  logic                r_rneg;
  logic [XLEN-1:0]     r_result;
  logic                r_zero;
  logic                r_out_valid;

  logic [SHW-1:0]      w_shamt;
  logic [XLEN-1:0]     w_alu_res;
  logic                w_is_mul, w_is_div, w_s1_signed, w_s2_signed;
  logic                w_neg1, w_neg2, w_div0, w_ovf;
  logic [XLEN-1:0]     w_mag1, w_mag2, w_fast_res, w_imm_res;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_acc_next, w_prod;
  logic [XLEN-1:0]     w_mul_res;
  logic [XLEN:0]       w_trial, w_diff;
  logic [XLEN-1:0]     w_rem_next, w_quo_next, w_div_res;
  logic                w_last;

  // Handshake: a request is taken when in_valid & in_ready (in_ready only in IDLE,
  // out of reset); a result leaves when out_valid & out_ready, returning to IDLE.
  assign in_ready     = (r_state == S_IDLE) && !rst;
  assign out_valid    = r_out_valid;
  assign result       = r_result;
  assign zero         = r_zero;
  assign res_last_bit = r_result[0];
  assign dbg_state    = r_state;

  always_comb begin
    w_shamt = src2[SHW-1:0];
    case (op)
      OP_ADD:  w_alu_res = src1 + src2;
      OP_SUB:  w_alu_res = src1 - src2;
      OP_AND:  w_alu_res = src1 & src2;
      OP_OR:   w_alu_res = src1 | src2;
      OP_XOR:  w_alu_res = src1 ^ src2;
      OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
      OP_SLL:  w_alu_res = src1 << w_shamt;
      OP_SRL:  w_alu_res = src1 >> w_shamt;
      OP_SRA:  w_alu_res = $signed(src1) >>> w_shamt;
      default: w_alu_res = '0;
    endcase
  end

  // Operand sign handling: magnitudes feed both iterative datapaths.
  always_comb begin
    w_is_mul    = (op[4:2] == 3'b100);
    w_is_div    = (op[4:2] == 3'b101);
    w_s1_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    w_s2_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    w_neg1      = w_s1_signed && src1[XLEN-1];
    w_neg2      = w_s2_signed && src2[XLEN-1];
    w_mag1      = w_neg1 ? -src1 : src1;
    w_mag2      = w_neg2 ? -src2 : src2;
    w_div0      = (src2 == '0);
    w_ovf       = ((op == OP_DIV) || (op == OP_REM)) && (src1 == MIN_VAL) && (&src2);
    if (w_div0)
      w_fast_res = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : src1;
    else
      w_fast_res = (op == OP_DIV) ? MIN_VAL : '0;
    w_imm_res = w_is_div ? w_fast_res : w_alu_res;
  end

  always_comb begin
    w_last     = (r_cnt == SHW'(XLEN-1));
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    w_prod     = r_neg ? -w_acc_next : w_acc_next;
    w_mul_res  = (r_sel == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    w_trial    = {r_rem, r_quo[XLEN-1]};
    w_diff     = w_trial - {1'b0, r_div};
    w_rem_next = w_diff[XLEN] ? w_trial[XLEN-1:0] : w_diff[XLEN-1:0];
    w_quo_next = {r_quo[XLEN-2:0], ~w_diff[XLEN]};
    if (r_sel[1])
      w_div_res = r_rneg ? -w_rem_next : w_rem_next;
    else
      w_div_res = r_neg ? -w_quo_next : w_quo_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_neg       <= 1'b0;
      r_rneg      <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_sel  <= op[1:0];
          r_cnt  <= '0;
          r_neg  <= w_neg1 ^ w_neg2;
          r_rneg <= w_neg1;
          if (w_is_mul) begin
            r_acc   <= {{XLEN{1'b0}}, w_mag2};
            r_mcand <= w_mag1;
            r_state <= S_MUL;
          end else if (w_is_div && !w_div0 && !w_ovf) begin
            r_rem   <= '0;
            r_quo   <= w_mag1;
            r_div   <= w_mag2;
            r_state <= S_DIV;
          end else begin
            r_result    <= w_imm_res;
            r_zero      <= (w_imm_res == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + SHW'(1);
          if (w_last) begin
            r_result    <= w_mul_res;
            r_zero      <= (w_mul_res == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + SHW'(1);
          if (w_last) begin
            r_result    <= w_div_res;
            r_zero      <= (w_div_res == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: a 32-bit instance plus an 8-bit instance sharing clk/rst.
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv32 = 1'b0, or32 = 1'b0;
  logic [4:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ir32, ov32, z32, lb32;
  logic [31:0] r32;
  logic [1:0]  st32;

  logic        iv8 = 1'b0, or8 = 1'b0;
  logic [4:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8, z8, lb8;
  logic [7:0]  r8;
  logic [1:0]  st8;

  logic        sel8 = 1'b0;
  logic        obs_valid, obs_ready, obs_zero, obs_lsb;
  logic [31:0] obs_res;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op32),
    .src1(a32), .src2(b32), .out_valid(ov32), .out_ready(or32),
    .result(r32), .zero(z32), .res_last_bit(lb32), .dbg_state(st32)
  );

  alu_mdu #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op8),
    .src1(a8), .src2(b8), .out_valid(ov8), .out_ready(or8),
    .result(r8), .zero(z8), .res_last_bit(lb8), .dbg_state(st8)
  );

  assign obs_valid = sel8 ? ov8 : ov32;
  assign obs_ready = sel8 ? ir8 : ir32;
  assign obs_zero  = sel8 ? z8 : z32;
  assign obs_lsb   = sel8 ? lb8 : lb32;
  assign obs_res   = sel8 ? {24'd0, r8} : r32;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    if (sel8) begin
      iv8 = 1'b1; op8 = o; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv32 = 1'b1; op32 = o; a32 = a; b32 = b;
    end
  endtask

  task automatic release_req();
    iv8 = 1'b0;
    iv32 = 1'b0;
  endtask

  task automatic set_out_ready(input logic v);
    if (sel8) or8 = v; else or32 = v;
  endtask

  // Issue one op, measure latency to out_valid, check outputs, then hand the result off.
  task automatic run_op(input bit w8, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input string tag);
    int lat;
    logic [31:0] e;
    sel8 = w8;
    exp_q.push_back(exp_res);
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, obs_ready}, 32'd1);
    drive_req(o, a, b);
    @(posedge clk);
    #1 release_req();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!obs_valid && lat < 100);
    check({tag, "_latency"}, lat, exp_lat);
    e = exp_q.pop_front();
    check({tag, "_result"}, obs_res, e);
    check({tag, "_zero"}, {31'd0, obs_zero}, {31'd0, e == 32'd0});
    check({tag, "_lsb"}, {31'd0, obs_lsb}, {31'd0, e[0]});
    set_out_ready(1'b1);
    @(posedge clk);
    #1 set_out_ready(1'b0);
    @(negedge clk);
    check({tag, "_valid_drop"}, {31'd0, obs_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, obs_ready}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, ov32}, 32'd0);
    check("rst_result", r32, 32'd0);
    check("rst_zero", {31'd0, z32}, 32'd1);
    check("rst_lsb", {31'd0, lb32}, 32'd0);
    check("rst_in_ready", {31'd0, ir32}, 32'd0);
    rst = 1'b0;
    #1 check("rst_release_ready", {31'd0, ir32}, 32'd1);

    // Reset mid-MUL, after 10 of 32 iterations
    sel8 = 1'b0;
    @(negedge clk);
    drive_req(5'd16, 32'd3, 32'd5);
    @(posedge clk);
    #1 release_req();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, ov32}, 32'd0);
    check("midrst_result", r32, 32'd0);
    check("midrst_zero", {31'd0, z32}, 32'd1);
    check("midrst_in_ready", {31'd0, ir32}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_ready_after", {31'd0, ir32}, 32'd1);
    run_op(0, 5'd0, 32'd1, 32'd2, 1, 32'd3, "add_after_rst");

    // Base ops
    run_op(0, 5'd1, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, "sub_neg");
    run_op(0, 5'd9, 32'h8000_0000, 32'd4, 1, 32'hF800_0000, "sra");
    run_op(0, 5'd5, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, "slt");
    run_op(0, 5'd6, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, "sltu");
    run_op(0, 5'd1, 32'd9, 32'd9, 1, 32'd0, "sub_zero");
    run_op(0, 5'd4, 32'hA5A5_A5A5, 32'hFFFF_0000, 1, 32'h5A5A_A5A5, "xor");
    run_op(0, 5'd7, 32'd1, 32'h0000_003F, 1, 32'h8000_0000, "sll_31");
    run_op(0, 5'd8, 32'h8000_0000, 32'd31, 1, 32'd1, "srl_31");
    run_op(0, 5'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200, "and");
    run_op(0, 5'd3, 32'hF000_0001, 32'h0000_0F00, 1, 32'hF000_0F01, "or");
    run_op(0, 5'd10, 32'd123, 32'd456, 1, 32'd0, "undef_op");

    // MUL family
    run_op(0, 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'd0, "mulh");
    run_op(0, 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, "mulhu");
    run_op(0, 5'd18, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFF, "mulhsu");
    run_op(0, 5'd16, 32'h0001_0000, 32'h0001_0000, 33, 32'd0, "mul_wrap");
    run_op(0, 5'd16, 32'hFFFF_FFF9, 32'd6, 33, 32'hFFFF_FFD6, "mul_neg");

    // DIV family
    run_op(0, 5'd20, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, "div_neg");
    run_op(0, 5'd22, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, "rem_neg");
    run_op(0, 5'd21, 32'd7, 32'd0, 1, 32'hFFFF_FFFF, "divu_by0");
    run_op(0, 5'd23, 32'd7, 32'd0, 1, 32'd7, "remu_by0");
    run_op(0, 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "rem_ovf");
    run_op(0, 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
    run_op(0, 5'd23, 32'd100, 32'd7, 33, 32'd2, "remu");

    // Backpressure: DIV 100/7 held in DONE for 5 cycles with an ADD request ignored
    sel8 = 1'b0;
    @(negedge clk);
    drive_req(5'd20, 32'd100, 32'd7);
    @(posedge clk);
    #1 release_req();
    begin
      int lat;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!ov32 && lat < 100);
      check("bp_latency", lat, 33);
    end
    drive_req(5'd0, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_result", r32, 32'd14);
      check("bp_out_valid", {31'd0, ov32}, 32'd1);
      check("bp_in_ready", {31'd0, ir32}, 32'd0);
      @(negedge clk);
    end
    release_req();
    or32 = 1'b1;
    @(posedge clk);
    #1 or32 = 1'b0;
    @(negedge clk);
    check("bp_valid_drop", {31'd0, ov32}, 32'd0);
    check("bp_ready_back", {31'd0, ir32}, 32'd1);
    run_op(0, 5'd0, 32'd40, 32'd2, 1, 32'd42, "add_after_bp");

    // 8-bit instance
    run_op(1, 5'd19, 32'hFF, 32'hFF, 9, 32'hFE, "x8_mulhu");
    run_op(1, 5'd7, 32'h01, 32'h0B, 1, 32'h08, "x8_sll");
    run_op(1, 5'd20, 32'hF9, 32'h02, 9, 32'hFD, "x8_div");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, multi-cycle execution unit for the rv32i_sc core's execute stage, extending the single-cycle integer ALU with RV32M multiply/divide. Base integer ops complete in one cycle; MUL* and DIV/REM* run on iterative shift-add and restoring-divide datapaths of XLEN steps. A valid/ready handshake on both sides lets the control unit stall the core while an operation is in flight. Outputs are registered and include the zero and LSB flags used for branch evaluation.

## Interface
- XLEN, 32, operand/result width; power of two, ≥ 8.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden).

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  high only in IDLE with rst low; accept = in_valid & in_ready.
- op  input  5  operation select, sampled on accept.
- src1  input  XLEN  first operand, sampled on accept.
- src2  input  XLEN  second operand (operand mux is upstream), sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result; handshake = out_valid & out_ready.
- result  output  XLEN  registered result.
- zero  output  1  result == 0, registered with result.
- res_last_bit  output  1  result[0].

## Operation
- op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU. Any other code: result 0, one-cycle path.
- Shifts use src2[SHW-1:0]; SRA is arithmetic. SLT/SLTU return {XLEN-1 zeros, cmp}.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on accept, base/undefined op or DIV fast case → compute, load result, go DONE. MUL* → MUL. DIV/REM* → DIV.
  - MUL: operand magnitudes (src1 signed for MULH/MULHSU; src2 signed for MULH only), one shift-add step per cycle into a 2·XLEN accumulator; after XLEN steps, negate if operand signs differ, select low half (MUL) or high half (others), go DONE.
  - DIV: restoring division on magnitudes (signed for DIV/REM), one quotient bit per cycle; after XLEN steps, quotient sign = sign1^sign2, remainder sign = sign1; select quotient (DIV/DIVU) or remainder (REM/REMU), go DONE.
  - DONE: out_valid=1; result, zero, res_last_bit held stable until out_ready; on handshake go IDLE.
- DIV fast cases, resolved in IDLE (no iteration): divisor 0 → DIV/DIVU all-ones, REM/REMU = src1; signed overflow (src1 = MIN, src2 = −1) → DIV = MIN, REM = 0.
- All arithmetic is modulo 2^XLEN; overflow is not flagged.
- Single operation in flight; in_valid outside IDLE is ignored and must not disturb the operation.

## Timing
- Reset (asynchronous): state IDLE, out_valid 0, result 0, zero 1, res_last_bit 0, iteration counter 0, accumulators 0. in_ready 0 while rst is high, 1 in the first cycle after release.
- Accept in cycle N:
  - base/undefined op or DIV fast case: out_valid in N+1.
  - MUL*/DIV*: out_valid in N+XLEN+1.
- Result handshake in cycle M → out_valid 0 and in_ready 1 in M+1; next accept no earlier than M+1. Base-op throughput is one op per two cycles with out_ready held high.
- out_ready low holds DONE indefinitely with all outputs constant.
- rst asserted mid-iteration or in DONE: immediate return to reset values; the in-flight result is discarded.
- in_ready is decoded from state; no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset mid-MUL (rst pulse at cycle 10 of 32) → out_valid 0, result 0, zero 1 immediately; next ADD 1+2 returns 3 at N+1.
- Base ops, XLEN=32: SUB 5−7 → 0xFFFFFFFE; SRA 0x80000000 by 4 → 0xF8000000; SLT −1<1 → 1, SLTU → 0; SUB 9−9 → result 0, zero 1. Each with out_valid at N+1.
- MUL family, XLEN=32: MULH 0xFFFFFFFF×0xFFFFFFFF → 0; MULHU same → 0xFFFFFFFE; MULHSU −1×2 → 0xFFFFFFFF; MUL 0x10000×0x10000 → 0. Each with out_valid at N+33.
- DIV family: DIV −7/2 → −3, REM → −1; DIVU 7/0 → 0xFFFFFFFF at N+1; REM 0x80000000/−1 → 0 at N+1.
- Backpressure: out_ready low for 5 cycles after DIV 100/7 → result 14 stable throughout, in_ready 0, in_valid with ADD ignored; handshake then in_ready 1 in the next cycle.
- XLEN=8 instance: MULHU 0xFF×0xFF → 0xFE at N+9; SLL 1 by src2=0x0B uses 3-bit shamt 3 → 0x08.
